adat_tx_frame_encoder: RTL and testbench

ADAT transmit-side framer and line encoder, the counterpart of the adat_rx receive chain. It accepts one 8-channel x 24-bit sample frame plus 4 user bits per word clock through a valid/ready handshake and double-buffers it. On an external bit-rate enable it serialises a 256-bit ADAT frame: sync, user nibble, then data nibbles with separators. Output is NRZI-encoded for the optical/TOSLINK driver.

---
 rtl/adat_tx_frame_encoder.sv | 178 +++++++++++++++++
 tb/tb_adat_tx_frame_encoder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adat_tx_frame_encoder.sv
// adat_tx_frame_encoder
// ADAT transmit framer and NRZI line encoder. One 8 x 24-bit sample frame plus
// four user bits is accepted per word clock into a holding buffer, moved into a
// 256-bit shift frame at each frame boundary, and serialised one bit per
// i_bit_en strobe: 10-bit sync, user nibble, then 48 separator+nibble groups.
//
// Build option: define ADAT_TX_HOLD_ON_UNDERRUN_EN to retransmit the previous
// frame (samples and user bits) when a boundary finds the buffer empty.
// Without it an underrun frame carries zero samples with the previous user bits.
module adat_tx_frame_encoder #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_CH     = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_bit_en,
    input  logic [DATA_WIDTH-1:0] i_channels [0:NUM_CH-1],
    input  logic [3:0]            i_user_bits,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_adat,
    output logic                  o_frame_start,
    output logic                  o_underrun,
    output logic                  o_active
);

    localparam int FRAME_BITS = 256;
    localparam int NIBBLES    = DATA_WIDTH / 4;
    localparam int CH_SLOT    = NIBBLES * 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Holding buffer (written by the handshake, drained at frame boundaries)
    logic                  r_hold_full;
    logic [DATA_WIDTH-1:0] r_hold_ch [0:NUM_CH-1];
    logic [3:0]            r_hold_user;

    // Content of the frame currently on the wire (source for underrun fill)
    logic [DATA_WIDTH-1:0] r_frame_ch [0:NUM_CH-1];
    logic [3:0]            r_frame_user;

    // Serialiser state
    state_t                r_state;
    logic [7:0]            r_bit_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_adat;
    logic                  r_frame_start;
    logic                  r_underrun;

    logic                  w_accept;
    logic                  w_consume;
    logic [DATA_WIDTH-1:0] w_src_ch [0:NUM_CH-1];
    logic [3:0]            w_src_user;
    logic [FRAME_BITS-1:0] w_frame_bits;

    assign w_accept  = i_valid && !r_hold_full;

    // The buffer is drained by the IDLE start strobe or by the b=255 strobe.
    // A transfer landing in the same cycle cannot be drained because the
    // buffer was empty going into that edge.
    assign w_consume = i_bit_en && r_hold_full &&
                       ((r_state == ST_IDLE) ||
                        ((r_state == ST_RUN) && (r_bit_cnt == 8'd255)));

    // Pick the samples for the next frame: the buffer if it holds one,
    // otherwise the underrun fill.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_src
`ifdef ADAT_TX_HOLD_ON_UNDERRUN_EN
            assign w_src_ch[gi] = r_hold_full ? r_hold_ch[gi] : r_frame_ch[gi];
`else
            assign w_src_ch[gi] = r_hold_full ? r_hold_ch[gi] : '0;
`endif
        end
    endgenerate

    assign w_src_user = r_hold_full ? r_hold_user : r_frame_user;

    // Frame image, wire order from the MSB down: bit b sits at FRAME_BITS-1-b.
    // Sync (10 zeros), marker 1, U3..U0, marker 1.
    assign w_frame_bits[FRAME_BITS-1 -: 16] = {10'b0, 1'b1, w_src_user, 1'b1};

    // Each channel: six groups of a 1 separator followed by a nibble, MSB first.
    genvar gn;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            for (gn = 0; gn < NIBBLES; gn++) begin : g_nib
                localparam int POS = FRAME_BITS - 1 - (16 + CH_SLOT * gi + 5 * gn);
                assign w_frame_bits[POS -: 5] =
                    {1'b1, w_src_ch[gi][DATA_WIDTH-1-4*gn -: 4]};
            end
        end
    endgenerate

    // Holding buffer: capture on handshake, free when moved to the shift frame
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_hold_full <= 1'b0;
            r_hold_user <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_hold_ch[i] <= '0;
            end
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold_user <= i_user_bits;
            for (int i = 0; i < NUM_CH; i++) begin
                r_hold_ch[i] <= i_channels[i];
            end
        end else if (w_consume) begin
            r_hold_full <= 1'b0;
        end
    end

    // Framer FSM: start on first buffered frame, then stream 256-bit frames forever
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= 8'd0;
            r_shift       <= '0;
            r_adat        <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_frame_user  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_frame_ch[i] <= '0;
            end
        end else begin
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            if (i_bit_en) begin
                case (r_state)
                    ST_IDLE: begin
                        // Start strobe only loads; the first bit goes out next strobe
                        if (r_hold_full) begin
                            r_shift      <= w_frame_bits;
                            r_bit_cnt    <= 8'd0;
                            r_state      <= ST_RUN;
                            r_frame_user <= w_src_user;
                            for (int i = 0; i < NUM_CH; i++) begin
                                r_frame_ch[i] <= w_src_ch[i];
                            end
                        end
                    end
                    ST_RUN: begin
                        // NRZI: a 1 toggles the line, a 0 holds it
                        r_adat        <= r_adat ^ r_shift[FRAME_BITS-1];
                        r_frame_start <= (r_bit_cnt == 8'd0);
                        r_bit_cnt     <= r_bit_cnt + 8'd1;
                        if (r_bit_cnt == 8'd255) begin
                            r_shift      <= w_frame_bits;
                            r_underrun   <= !r_hold_full;
                            r_frame_user <= w_src_user;
                            for (int i = 0; i < NUM_CH; i++) begin
                                r_frame_ch[i] <= w_src_ch[i];
                            end
                        end else begin
                            r_shift <= r_shift << 1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_ready       = !r_hold_full;
    assign o_adat        = r_adat;
    assign o_frame_start = r_frame_start;
    assign o_underrun    = r_underrun;
    assign o_active      = (r_state == ST_RUN);

endmodule

// File: tb/tb_adat_tx_frame_encoder.sv
// Testbench for adat_tx_frame_encoder: directed frames, NRZI decoding monitor
// and an expected-frame scoreboard. Build with +define+ADAT_TX_HOLD_ON_UNDERRUN_EN
// to match an RTL build that has the hold-on-underrun option enabled.
`timescale 1ns/1ps
module tb_adat_tx_frame_encoder;

    logic        i_clk    = 1'b0;
    logic        i_rst    = 1'b1;
    logic        i_bit_en = 1'b0;
    logic        i_valid  = 1'b0;
    logic [23:0] ch_in   [0:7];
    logic [23:0] zero_ch [0:7];
    logic [3:0]  user_in = 4'b0000;
    logic        o_ready, o_adat, o_frame_start, o_underrun, o_active;

    adat_tx_frame_encoder dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_bit_en     (i_bit_en),
        .i_channels   (ch_in),
        .i_user_bits  (user_in),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_adat       (o_adat),
        .o_frame_start(o_frame_start),
        .o_underrun   (o_underrun),
        .o_active     (o_active)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp     = 0;
    int n_bad     = 0;
    int strobe_no = 0;
    int strobe_ph = 0;
    int fs_count  = 0;

    typedef struct {
        logic [255:0] bits;
        int           urun;
        int           tag;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Expected wire bits of one frame, index = bit position b on the wire
    function automatic logic [255:0] build_frame(input logic [23:0] c [0:7], input logic [3:0] u);
        logic [255:0] f;
        int b;
        f     = '0;
        f[10] = 1'b1;
        f[11] = u[3];
        f[12] = u[2];
        f[13] = u[1];
        f[14] = u[0];
        f[15] = 1'b1;
        b = 16;
        for (int ch = 0; ch < 8; ch++) begin
            for (int n = 0; n < 6; n++) begin
                f[b] = 1'b1;
                b++;
                for (int k = 0; k < 4; k++) begin
                    f[b] = c[ch][23 - 4 * n - k];
                    b++;
                end
            end
        end
        return f;
    endfunction

    task automatic push_exp(input logic [255:0] bits, input int urun, input int tag);
        exp_t e;
        e.bits = bits;
        e.urun = urun;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    // Bit-rate strobe: one cycle high every 4 clocks
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (strobe_ph == 3) begin
                i_bit_en = 1'b1;
                strobe_no++;
            end else begin
                i_bit_en = 1'b0;
            end
            strobe_ph = (strobe_ph + 1) % 4;
        end
    end

    // Monitor: decode NRZI after each emitting strobe, assemble and score frames
    logic [255:0] cur;
    int   idx        = 0;
    bit   in_frame   = 1'b0;
    bit   pend       = 1'b0;
    logic prev_adat  = 1'b0;
    int   urun_cnt   = 0;
    int   frame_urun = 0;

    task automatic score_frame();
        exp_t e;
        logic [47:0] seps;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame: got %h, expected no frame", cur);
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if (cur !== e.bits) begin
                n_bad++;
                $display("FAIL frame_bits tag=%0d: got %h, expected %h", e.tag, cur, e.bits);
            end
            chk("frame_underrun", frame_urun, e.urun);
            chk("frame_active", {31'd0, o_active}, 32'd1);
            for (int m = 0; m < 48; m++) begin
                seps[m] = cur[16 + 5 * m];
            end
            chk("sync_zero_bits", {22'd0, cur[9:0]}, 32'd0);
            chk("sync_markers", {30'd0, cur[10], cur[15]}, 32'd3);
            chk("separators_lo", seps[31:0], 32'hFFFF_FFFF);
            chk("separators_hi", {16'd0, seps[47:32]}, 32'h0000_FFFF);
            $display("frame tag=%0d underrun=%0d compared (%0d mismatched so far)", e.tag, frame_urun, n_bad);
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_rst) begin
            in_frame  = 1'b0;
            idx       = 0;
            pend      = 1'b0;
            urun_cnt  = 0;
            prev_adat = o_adat;
        end else begin
            if (pend) begin
                if (o_frame_start) begin
                    fs_count++;
                    chk("frame_start_spacing", {31'd0, in_frame}, 32'd0);
                    in_frame   = 1'b1;
                    idx        = 0;
                    frame_urun = urun_cnt;
                    urun_cnt   = 0;
                end
                if (in_frame) begin
                    cur[idx] = o_adat ^ prev_adat;
                    idx++;
                    if (idx == 256) begin
                        in_frame = 1'b0;
                        score_frame();
                    end
                end
            end else if (o_frame_start) begin
                n_cmp++;
                n_bad++;
                $display("FAIL frame_start_off_strobe: got 1, expected 0");
            end
            if (o_underrun) urun_cnt++;
            prev_adat = o_adat;
            pend      = i_bit_en && o_active;
        end
    end

    // Stimulus helpers
    task automatic wait_ready(output int waited);
        waited = 0;
        while (!o_ready && waited < 2000) begin
            @(negedge i_clk);
            waited++;
        end
        if (!o_ready) chk("ready_timeout", {31'd0, o_ready}, 32'd1);
    endtask

    task automatic push_frame();
        @(posedge i_clk);
        #1 i_valid = 1'b1;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic wait_fs(input int n, output int base);
        int guard;
        guard = 0;
        while (fs_count < n && guard < 3000) begin
            @(negedge i_clk);
            guard++;
        end
        if (fs_count < n) chk("frame_start_timeout", fs_count, n);
        base = strobe_no;
    endtask

    task automatic wait_strobe(input int target);
        int guard;
        guard = 0;
        while (strobe_no < target && guard < 3000) begin
            @(negedge i_clk);
            guard++;
        end
        if (strobe_no < target) chk("strobe_timeout", strobe_no, target);
    endtask

    logic [255:0] fill_bits;

    initial begin
        int waited;
        int base;
        for (int k = 0; k < 8; k++) begin
            zero_ch[k] = '0;
            ch_in[k]   = '0;
        end

        // Asynchronous reset before any clock edge
        #3 i_rst = 1'b0;
        #1;
        chk("reset_adat", {31'd0, o_adat}, 32'd0);
        chk("reset_ready", {31'd0, o_ready}, 32'd1);
        chk("reset_frame_start", {31'd0, o_frame_start}, 32'd0);
        chk("reset_underrun", {31'd0, o_underrun}, 32'd0);
        chk("reset_active", {31'd0, o_active}, 32'd0);
        repeat (4) @(posedge i_clk);
        #1 i_rst = 1'b1;

        // Frame A: ch k = 0xAA000k, user 0000
        for (int k = 0; k < 8; k++) ch_in[k] = 24'(32'hAA0000 + k);
        user_in = 4'b0000;
        push_exp(build_frame(ch_in, user_in), 0, 1);
        push_frame();
        chk("ready_low_after_A", {31'd0, o_ready}, 32'd0);

        // Five back-to-back frames with the S/MUX2 user bit set
        for (int i = 1; i <= 5; i++) begin
            wait_ready(waited);
            if (i > 1) begin
                n_cmp++;
                if (waited < 1000 || waited > 1030) begin
                    n_bad++;
                    $display("FAIL ready_low_duration B%0d: got %0d cycles, expected 1000..1030", i, waited);
                end
            end
            for (int k = 0; k < 8; k++) ch_in[k] = 24'(32'hC00000 + (i << 12) + (k << 4) + i);
            user_in = 4'b0010;
            push_exp(build_frame(ch_in, user_in), 0, 1 + i);
            push_frame();
            chk("ready_low_after_B", {31'd0, o_ready}, 32'd0);
        end

        // Nothing more pushed: the frame after B5 is an underrun fill
`ifdef ADAT_TX_HOLD_ON_UNDERRUN_EN
        fill_bits = build_frame(ch_in, 4'b0010);
`else
        fill_bits = build_frame(zero_ch, 4'b0010);
`endif
        push_exp(fill_bits, 1, 7);

        // Collision: valid arrives with the b=255 strobe of the fill frame
        wait_fs(7, base);
        wait_strobe(base + 255);
        for (int k = 0; k < 8; k++) ch_in[k] = 24'(32'h123456 + k * 32'h010101);
        user_in = 4'b0110;
        i_valid = 1'b1;
        push_exp(fill_bits, 1, 8);
        push_exp(build_frame(ch_in, user_in), 0, 9);
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        chk("ready_low_after_collision", {31'd0, o_ready}, 32'd0);

        // During frame C: buffer frame D, then reset at b=100
        wait_fs(9, base);
        wait_ready(waited);
        for (int k = 0; k < 8; k++) ch_in[k] = 24'hFFFFFF;
        user_in = 4'b1111;
        push_frame();
        chk("ready_low_after_D", {31'd0, o_ready}, 32'd0);
        wait_strobe(base + 100);
        @(posedge i_clk);
        #2 i_rst = 1'b0;
        #1;
        chk("midreset_adat", {31'd0, o_adat}, 32'd0);
        chk("midreset_ready", {31'd0, o_ready}, 32'd1);
        chk("midreset_active", {31'd0, o_active}, 32'd0);
        chk("midreset_underrun", {31'd0, o_underrun}, 32'd0);
        exp_q.delete();
        repeat (5) @(posedge i_clk);
        #1 i_rst = 1'b1;

        // Idle after release: no emission until a new frame is pushed
        repeat (600) @(posedge i_clk);
        #1;
        chk("idle_active", {31'd0, o_active}, 32'd0);
        chk("idle_adat", {31'd0, o_adat}, 32'd0);
        chk("idle_ready", {31'd0, o_ready}, 32'd1);
        chk("idle_no_frames", fs_count, 32'd9);

        // Frame E streams from b0
        for (int k = 0; k < 8; k++) ch_in[k] = 24'(32'h0F0F0F ^ (k << 20));
        user_in = 4'b1001;
        push_exp(build_frame(ch_in, user_in), 0, 10);
        push_frame();

        waited = 0;
        while (exp_q.size() != 0 && waited < 3000) begin
            @(negedge i_clk);
            waited++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
